// File: rtl/shift_cmd_sequencer.sv
// Command front-end for a universal shift register: turns load/shift/rotate
// commands into per-cycle mode-select, parallel-load and serial-input drive.
module shift_cmd_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] q_fb,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] p_in,
  output logic             serial_right,
  output logic             serial_left,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_ROL  = 3'd5;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [2:0]       op_q, op_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic             fill_q, fill_nxt;
  logic [1:0]       sel_nxt;
  logic [WIDTH-1:0] p_in_nxt;
  logic             busy_nxt, done_nxt, err_nxt, ready_nxt;
  logic             accept, is_shift_op;

  // Only the end bits of q_fb feed the rotate path.
  logic unused_q_fb;
  assign unused_q_fb = ^q_fb;

  assign accept      = cmd_valid && (state == S_IDLE);
  assign is_shift_op = (cmd_op >= OP_SHR) && (cmd_op <= OP_ROL);

  // Next state, latched command and registered-output decode of the next state.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    op_nxt    = op_q;
    data_nxt  = data_q;
    fill_nxt  = fill_q;
    sel_nxt   = SEL_HOLD;
    p_in_nxt  = '0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    ready_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          op_nxt   = cmd_op;
          data_nxt = cmd_data;
          fill_nxt = cmd_fill;
          if (cmd_op == OP_LOAD) begin
            state_nxt = S_LOAD;
          end else if (is_shift_op && (cmd_amt != '0)) begin
            state_nxt = S_SHIFT;
            count_nxt = cmd_amt;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_LOAD:  state_nxt = S_DONE;
      S_SHIFT: begin
        count_nxt = count - CNT_W'(1);
        if (count == CNT_W'(1)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_LOAD: begin
        sel_nxt  = SEL_LOAD;
        p_in_nxt = data_nxt;
      end
      S_SHIFT: sel_nxt = ((op_nxt == OP_SHR) || (op_nxt == OP_ROR)) ? SEL_SHR : SEL_SHL;
      S_DONE: begin
        done_nxt = 1'b1;
        err_nxt  = (op_nxt[2:1] == 2'b11);
      end
      default: ready_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      op_q      <= '0;
      data_q    <= '0;
      fill_q    <= 1'b0;
      sel       <= SEL_HOLD;
      p_in      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      op_q      <= op_nxt;
      data_q    <= data_nxt;
      fill_q    <= fill_nxt;
      sel       <= sel_nxt;
      p_in      <= p_in_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      cmd_ready <= ready_nxt;
    end
  end

  // Serial inputs; rotate bits come straight from the live register contents.
  always_comb begin
    serial_right = 1'b0;
    serial_left  = 1'b0;
    if (state == S_SHIFT) begin
      case (op_q)
        OP_SHR:  serial_right = fill_q;
        OP_SHL:  serial_left  = fill_q;
        OP_ROR:  serial_right = q_fb[0];
        OP_ROL:  serial_left  = q_fb[WIDTH-1];
        default: begin
          serial_right = 1'b0;
          serial_left  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed bench for shift_cmd_sequencer: models the downstream 4-bit register
// and checks every cycle's outputs against a queue of expected cycles.
module tb_shift_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_amt;
  logic [3:0] cmd_data;
  logic       cmd_fill;
  logic [3:0] q_fb;
  logic [1:0] sel;
  logic [3:0] p_in;
  logic       serial_right;
  logic       serial_left;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  // ser: 0 none, 1 fill->right, 2 fill->left, 3 rotate right, 4 rotate left
  typedef struct {
    logic [1:0] sel;
    logic [3:0] p;
    logic       busy;
    logic       done;
    logic       err;
    logic       ready;
    int         ser;
    logic       fill;
  } exp_t;

  exp_t sb[$];

  shift_cmd_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .q_fb(q_fb), .sel(sel), .p_in(p_in), .serial_right(serial_right),
    .serial_left(serial_left), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream universal shift register model.
  always @(posedge clk) begin
    if (rst) q_fb <= 4'b0000;
    else begin
      case (sel)
        2'b01:   q_fb <= {serial_right, q_fb[3:1]};
        2'b10:   q_fb <= {q_fb[2:0], serial_left};
        2'b11:   q_fb <= p_in;
        default: q_fb <= q_fb;
      endcase
    end
  end

  function automatic exp_t mk(input logic [1:0] s, input logic [3:0] p, input logic b,
                              input logic d, input logic e, input logic r,
                              input int ser, input logic f);
    exp_t x;
    x.sel = s; x.p = p; x.busy = b; x.done = d; x.err = e; x.ready = r;
    x.ser = ser; x.fill = f;
    return x;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle outputs for one accepted command, starting the cycle after accept.
  task automatic push_cmd(input logic [2:0] op, input logic [2:0] amt,
                          input logic [3:0] data, input logic fill);
    if (op == 3'd1) begin
      sb.push_back(mk(2'b11, data, 1, 0, 0, 0, 0, 0));
    end else if (op >= 3'd2 && op <= 3'd5 && amt != 0) begin
      for (int i = 0; i < int'(amt); i++)
        sb.push_back(mk((op == 3'd2 || op == 3'd4) ? 2'b01 : 2'b10, 4'h0, 1, 0, 0, 0,
                        int'(op) - 1, fill));
    end
    sb.push_back(mk(2'b00, 4'h0, 1, 1, (op >= 3'd6), 0, 0, 0));
  endtask

  task automatic tick();
    exp_t e;
    logic esr, esl;
    @(posedge clk);
    #1;
    if (sb.size() != 0) e = sb.pop_front();
    else e = mk(2'b00, 4'h0, 0, 0, 0, 1, 0, 0);
    esr = 1'b0;
    esl = 1'b0;
    case (e.ser)
      1: esr = e.fill;
      2: esl = e.fill;
      3: esr = q_fb[0];
      4: esl = q_fb[3];
      default: ;
    endcase
    check("sel", 8'(sel), 8'(e.sel));
    check("p_in", 8'(p_in), 8'(e.p));
    check("busy", 8'(busy), 8'(e.busy));
    check("done", 8'(done), 8'(e.done));
    check("err", 8'(err), 8'(e.err));
    check("cmd_ready", 8'(cmd_ready), 8'(e.ready));
    check("serial_right", 8'(serial_right), 8'(esr));
    check("serial_left", 8'(serial_left), 8'(esl));
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [2:0] amt,
                         input logic [3:0] data, input logic fill);
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; cmd_data = data; cmd_fill = fill;
    push_cmd(op, amt, data, fill);
    tick();
    cmd_valid = 1'b0;
    while (sb.size() != 0) tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_amt = '0; cmd_data = '0; cmd_fill = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_cmd(3'd1, 3'd0, 4'b1011, 1'b0);
    check("q_after_load", 8'(q_fb), 8'h0b);

    run_cmd(3'd1, 3'd0, 4'b0000, 1'b0);
    run_cmd(3'd2, 3'd3, 4'b0000, 1'b1);
    check("q_after_shr_fill", 8'(q_fb), 8'h0e);

    run_cmd(3'd1, 3'd0, 4'b1001, 1'b0);
    run_cmd(3'd4, 3'd2, 4'b0000, 1'b0);
    check("q_after_ror", 8'(q_fb), 8'h06);

    run_cmd(3'd2, 3'd0, 4'b0000, 1'b1);
    run_cmd(3'd0, 3'd5, 4'b1111, 1'b1);
    run_cmd(3'd6, 3'd3, 4'b1111, 1'b1);
    check("q_after_noops", 8'(q_fb), 8'h06);

    // ROL amt=5 aborted by reset during its second shift cycle
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_amt = 3'd5; cmd_data = 4'h0; cmd_fill = 1'b0;
    push_cmd(3'd5, 3'd5, 4'h0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    tick();

    run_cmd(3'd1, 3'd0, 4'b0011, 1'b0);
    check("q_after_abort_load", 8'(q_fb), 8'h03);

    // cmd_valid held high across two commands: SHL_FILL x2 then LOAD 0101
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_amt = 3'd2; cmd_data = 4'h0; cmd_fill = 1'b1;
    push_cmd(3'd3, 3'd2, 4'h0, 1'b1);
    sb.push_back(mk(2'b00, 4'h0, 0, 0, 0, 1, 0, 0));
    tick();
    cmd_op = 3'd1; cmd_amt = 3'd0; cmd_data = 4'b0101; cmd_fill = 1'b0;
    push_cmd(3'd1, 3'd0, 4'b0101, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    cmd_valid = 1'b0;
    while (sb.size() != 0) tick();
    tick();
    check("q_after_back_to_back", 8'(q_fb), 8'h05);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
- Command front-end that sits directly upstream of the 4-bit universal shift register.
- Accepts one command per valid/ready handshake: load, shift-with-fill or rotate, with a repeat count.
- Sequences the register's mode-select, parallel-load and serial-input lines over the required number of cycles, then pulses done.
- Reads the register's output (q_fb) back to generate rotate feedback bits.

Parameters:
- WIDTH, 4, data width of the driven register (p_in, q_fb, cmd_data).
- CNT_W, 3, width of the shift/rotate count; maximum count is 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  3  000 NOP, 001 LOAD, 010 SHR_FILL, 011 SHL_FILL, 100 ROR, 101 ROL, 11x reserved
- cmd_amt  input  CNT_W  number of shift/rotate cycles (ignored for LOAD/NOP)
- cmd_data  input  WIDTH  parallel value for LOAD
- cmd_fill  input  1  serial fill bit for SHR_FILL/SHL_FILL
- q_fb  input  WIDTH  current downstream register contents
- sel  output  2  register mode: 00 hold, 01 shift-right, 10 shift-left, 11 parallel load
- p_in  output  WIDTH  parallel-load data
- serial_right  output  1  serial input used in shift-right mode
- serial_left  output  1  serial input used in shift-left mode
- busy  output  1  command in progress
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse, coincident with done, for a reserved op

Behaviour:
- Reset is synchronous: at the first rising edge with rst=1, state goes to IDLE. cmd_ready=1, sel=00, p_in=0, serial_right=0, serial_left=0, busy=0, done=0, err=0, count=0, latched command cleared.
- rst asserted mid-command aborts at that edge; sel returns to 00 in the same cycle the new state takes effect, and no done is produced.
- States: IDLE, LOAD, SHIFT, DONE.
- cmd_ready=1 only in IDLE. A command is accepted at a rising edge with cmd_valid & cmd_ready; op, amt, data and fill are latched at that edge.
- Transitions from IDLE on accept:
  - LOAD -> LOAD
  - SHR_FILL/SHL_FILL/ROR/ROL with amt!=0 -> SHIFT, count=amt
  - NOP, any shift/rotate with amt=0, or reserved op -> DONE
- LOAD state lasts one cycle: sel=11, p_in=latched data. Next state is DONE.
- SHIFT state: sel=01 for SHR_FILL/ROR, sel=10 for SHL_FILL/ROL. count decrements every cycle; when count==1, next state is DONE. Exactly amt SHIFT cycles are produced.
- Serial lines in SHIFT:
  - SHR_FILL: serial_right = latched fill.
  - SHL_FILL: serial_left = latched fill.
  - ROR: serial_right = q_fb[0], combinational from live q_fb each cycle.
  - ROL: serial_left = q_fb[WIDTH-1], combinational from live q_fb each cycle.
  - The unused serial line is 0.
- Outside SHIFT both serial lines are 0. Outside LOAD p_in=0.
- DONE state lasts one cycle: done=1, sel=00. err=1 if the latched op was reserved. Next state is IDLE.
- busy=1 in LOAD, SHIFT and DONE.
- Latency from accept edge to done: NOP/amt=0/reserved = 1 cycle; LOAD = 2 cycles; shift/rotate = amt+1 cycles.
- Back-to-back commands: earliest next accept is the edge after DONE, i.e. one IDLE cycle between commands.
- cmd_* inputs are ignored while not in IDLE. cmd_valid held high across a command is not re-accepted until IDLE.
- sel, p_in, busy, done and err are decoded from registered state only (no input-to-output combinational path). The sole exception is the rotate serial bit taken from q_fb.

Test Plan:
- Reset then LOAD data=4'b1011 -> one cycle with sel=11, p_in=1011; done pulses 2 cycles after accept; model register q=1011; err=0.
- SHR_FILL amt=3 fill=1 from q=0000 -> exactly 3 cycles of sel=01 with serial_right=1; model q=1110; done pulses 4 cycles after accept.
- ROR amt=2 from q=1001 -> serial_right follows q_fb[0] (1 then 0); model q=0110; sel=01 for 2 cycles, then 00.
- SHIFT with amt=0, NOP, and op=110 -> done 1 cycle after accept, sel never leaves 00; err=1 only for op=110.
- rst asserted on the 2nd cycle of ROL amt=5 -> next edge IDLE, sel=00, cmd_ready=1, no done; a following LOAD is accepted normally.
- cmd_valid held high across two queued commands -> second accepted only on the edge after DONE; cmd_ready=0 throughout busy.
